// File: rtl/skew_feeder_pkg.sv
// skew_feeder shared types: feeder FSM state and element width.
// Imported by skew_feeder and skew_delay_line.
package skew_feeder_pkg;

  localparam int NUM_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage {valid, data} shift chain.
// en_i low holds every stage; async active-high reset clears it.
module skew_delay_line
  import skew_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int W1 = WIDTH + 1;
  localparam int SW = DEPTH * W1;

  logic [SW-1:0] sr_q;

  // shift a new {valid, data} word in at the bottom each enabled cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= (sr_q << W1) | SW'({valid_i, data_i});
    end
  end

  assign {valid_o, data_o} = sr_q[SW-1 -: W1];

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: diagonal-skew input feeder for the systolic array.
// Optional stall input enabled by defining SKEW_FEEDER_STALL_EN.
module skew_feeder #(
  parameter int NUM_BITS = skew_feeder_pkg::NUM_BITS,
  parameter int ROWS     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef SKEW_FEEDER_STALL_EN
  input  logic                     stall_i,
`endif
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ROWS*NUM_BITS-1:0] in_data_i,
  input  logic                     in_last_i,
  output logic [ROWS*NUM_BITS-1:0] left_o,
  output logic [ROWS-1:0]          lane_valid_o,
  output logic                     busy_o,
  output logic                     done_o
);

  import skew_feeder_pkg::*;

  localparam int CW = $clog2(ROWS) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ROWS - 1);

  feeder_state_t state_q;
  feeder_state_t state_d;
  logic [CW-1:0] cnt_q;
  logic          adv;
  logic          accept;
  logic          cnt_zero;

`ifdef SKEW_FEEDER_STALL_EN
  assign adv = ~stall_i;
`else
  assign adv = 1'b1;
`endif

  assign in_ready_o = (state_q != DRAIN) & adv;
  assign accept     = in_valid_i & in_ready_o;
  assign cnt_zero   = (cnt_q == '0);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DRAIN) & cnt_zero & adv;

  // next-state decode for IDLE/STREAM/DRAIN
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == DRAIN): begin
        if (cnt_zero) state_d = IDLE;
      end
      (state_q == IDLE),
      (state_q == STREAM): begin
        if (accept) state_d = in_last_i ? DRAIN : STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and drain counter; both freeze while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (adv) begin
      state_q <= state_d;
      if (accept && in_last_i) begin
        cnt_q <= CNT_INIT;
      end else if (state_q == DRAIN && !cnt_zero) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic                v;
    logic [NUM_BITS-1:0] d;
    logic [NUM_BITS-1:0] din;

    assign din = accept ? in_data_i[r*NUM_BITS +: NUM_BITS] : '0;

    skew_delay_line #(
      .DEPTH (r + 1),
      .WIDTH (NUM_BITS)
    ) u_dl (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (adv),
      .valid_i (accept),
      .data_i  (din),
      .valid_o (v),
      .data_o  (d)
    );

    assign lane_valid_o[r] = v;
    assign left_o[r*NUM_BITS +: NUM_BITS] = v ? d : '0;
  end

endmodule

// File: doc/skew_feeder.md
# skew_feeder

Input-side feeder for the weight-stationary systolic array. It accepts one B vector per cycle over a valid/ready handshake and applies the diagonal skew: row r of each vector reaches the left edge of array row r exactly r cycles after row 0. After the last vector it flushes the skew pipeline and pulses done. It sits directly upstream of the leftmost PE column and drives each row's `left_i`.

## Interface
Parameters:
- `NUM_BITS`, default pkg `NUM_BITS`: element width.
- `ROWS`, default 4: number of array rows (lanes); ROWS ≥ 1.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic on posedge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `in_valid_i`  in  1  input vector valid.
- `in_ready_o`  out  1  feeder can accept a vector this cycle.
- `in_data_i`  in  ROWS*NUM_BITS  vector; lane r = bits [r*NUM_BITS +: NUM_BITS].
- `in_last_i`  in  1  marks the final vector of a stream; sampled only on an accepted beat.
- `left_o`  out  ROWS*NUM_BITS  skewed lanes to array row r `left_i`.
- `lane_valid_o`  out  ROWS  lane r carries a real element this cycle.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle pulse when the last element leaves lane ROWS-1.
- `stall_i`  in  1  present only with `SKEW_FEEDER_STALL_EN`.

## Operation
- FSM (`feeder_state_t`): IDLE, STREAM, DRAIN.
- IDLE: `in_ready_o`=1. An accepted beat with `in_last_i`=0 goes to STREAM. An accepted beat with `in_last_i`=1 goes straight to DRAIN.
- STREAM: `in_ready_o`=1. An accepted beat with `in_last_i`=1 goes to DRAIN. A cycle with no accepted beat inserts a bubble: zero data, valid low, carried down the skew like a real beat.
- DRAIN: `in_ready_o`=0. A down-counter is loaded with ROWS-1 on entry. `done_o`=1 when the counter is 0, then the FSM returns to IDLE. DRAIN lasts exactly ROWS cycles.
- Accepted beat = `in_valid_i & in_ready_o`.
- Lane r is a (r+1)-deep register chain of {valid, data}. The chain is fed with {1, in_data_i lane r} on an accepted beat, otherwise {0, 0}.
- `left_o` lane r is zero whenever `lane_valid_o[r]`=0; data is never left stale.
- No arithmetic is performed; data passes bit-exact. The drain counter is $clog2(ROWS)+1 bits wide, so ROWS=1 is legal.
- Reset (asserted at any time, including mid-stream or mid-DRAIN): FSM goes to IDLE and all chains, counter and outputs clear. In-flight data is discarded and no `done_o` is produced.
- Reset values: `in_ready_o`=1 (combinational from IDLE), `left_o`=0, `lane_valid_o`=0, `busy_o`=0, `done_o`=0.

## Timing
- Beat accepted in cycle t: lane r is valid with that beat's data in cycle t+1+r. Latency is 1 cycle for lane 0 and ROWS cycles for lane ROWS-1.
- Last beat accepted in cycle t:
  - DRAIN covers cycles t+1 … t+ROWS.
  - `done_o` is high in cycle t+ROWS, coincident with `lane_valid_o[ROWS-1]`.
  - IDLE from t+ROWS+1; a new beat can be accepted in cycle t+ROWS+1.
- `in_ready_o` is combinational from state (and `stall_i`); it does not depend on `in_valid_i`.
- `busy_o` is registered via state: high from the cycle after the first accepted beat through the last DRAIN cycle.

## Configuration
- `SKEW_FEEDER_STALL_EN` defined:
  - Adds the `stall_i` port.
  - While `stall_i`=1: all chains, FSM and counter hold; `in_ready_o`=0; `left_o`/`lane_valid_o` hold their values; `done_o`=0.
  - A DRAIN-final cycle that is stalled asserts `done_o` in the first unstalled cycle.
- Not defined: no `stall_i` port and the pipeline always advances.

## Structure
- The shared package holds the `feeder_state_t` enum (IDLE, STREAM, DRAIN); `NUM_BITS` is already there.
- Sub-module `skew_delay_line` (parameters `DEPTH`, `WIDTH`), instantiated once per lane with DEPTH=r+1. Registered {valid, data} shift chain with async reset and a hold enable (tied high unless the stall feature is enabled).

## Test plan
- **Reset mid-stream:** ROWS=4; feed beats 1,2 then assert `rst_i` asynchronously → all outputs 0 immediately, IDLE, no `done_o`.
- **Single-beat stream:** ROWS=4, lanes {0x11,0x22,0x33,0x44}, last=1, accepted cycle 0 → lane r valid = 0x11*(r+1) in cycle 1+r; `done_o` in cycle 4; `in_ready_o`=0 in cycles 1–4.
- **Back-to-back stream:** 3 beats in cycles 0–2, last on beat 3 → lane 3 valid in cycles 4,5,6; `done_o` in cycle 6; next beat accepted in cycle 7.
- **Bubble:** `in_valid_i` low in cycle 1 between beats in cycles 0 and 2 → each lane shows valid, 0/invalid, valid; invalid lanes drive zero.
- **ROWS=1:** last beat in cycle 0 → lane 0 valid in cycle 1, `done_o` in cycle 1, accept again in cycle 2.
- **Stall (macro on):** `stall_i` high in cycle 3 of a single-beat ROWS=4 stream → outputs frozen for one cycle; `done_o` moves to cycle 5.
